// File: rtl/rf80386_bus_arb.sv
// rf80386 two-port FTA bus arbiter: shares one 128-bit master port between instruction refill and data paths.
// Optional lost-transaction timeout is enabled by defining RF80386_ARB_TIMEOUT_EN.

package rf80386_fta_pkg;

    typedef enum logic [3:0] {
        CMD_NONE  = 4'd0,
        CMD_LOAD  = 4'd1,
        CMD_LOADZ = 4'd2,
        CMD_STORE = 4'd3,
        CMD_IN    = 4'd4,
        CMD_OUT   = 4'd5
    } fta_cmd_t;

    typedef struct packed {
        logic [5:0] core;
        logic [2:0] channel;
        logic [3:0] tranid;
    } fta_tranid_t;

    typedef struct packed {
        fta_cmd_t      cmd;
        fta_tranid_t   tid;
        logic          cyc;
        logic          stb;
        logic          we;
        logic [15:0]   sel;
        logic [31:0]   adr;
        logic [127:0]  dat;
    } fta_cmd_request128_t;

    typedef struct packed {
        fta_tranid_t   tid;
        logic          ack;
        logic          err;
        logic          rty;
        logic [127:0]  dat;
    } fta_cmd_response128_t;

endpackage

module rf80386_bus_arb
    import rf80386_fta_pkg::*;
#(
    parameter logic [5:0] CORENO      = 6'd1,
    parameter logic [2:0] CID         = 3'd1,
    parameter int         RTY_BACKOFF = 8,
    parameter int         TIMEOUT     = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  fta_cmd_request128_t  ireq_i,
    output fta_cmd_response128_t iresp_o,
    input  fta_cmd_request128_t  dreq_i,
    output fta_cmd_response128_t dresp_o,
    output fta_cmd_request128_t  ftam_req,
    input  fta_cmd_response128_t ftam_resp,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_BACKOFF = 2'd3
    } state_t;

    state_t               state_r, state_s;
    fta_cmd_request128_t  hold_r;
    fta_cmd_request128_t  win_req_s;
    fta_cmd_request128_t  issue_src_s;
    fta_cmd_request128_t  ftam_req_r, ftam_req_s;
    fta_cmd_response128_t iresp_r, dresp_r, resp_s;
    logic                 owner_d_r;
    logic                 last_d_r;
    logic                 settle_r;
    logic [3:0]           cur_tid_r;
    logic [3:0]           next_tid_r;
    logic [7:0]           bo_cnt_r;
    logic                 grant_s;
    logic                 grant_d_s;
    logic                 match_s;
    logic                 done_s;
    logic                 retire_s;
    logic                 owner_cyc_s;
    logic                 timeout_s;

`ifdef RF80386_ARB_TIMEOUT_EN
    logic [9:0]           to_cnt_r;

    assign timeout_s = (to_cnt_r == 10'(TIMEOUT - 1));
`else
    assign timeout_s = 1'b0;
`endif

    assign match_s     = (ftam_resp.tid.tranid == cur_tid_r);
    assign owner_cyc_s = owner_d_r ? dreq_i.cyc : ireq_i.cyc;

    // Next-state, arbitration and response selection.
    always_comb begin
        state_s   = state_r;
        grant_s   = 1'b0;
        grant_d_s = 1'b0;
        win_req_s = dreq_i;
        done_s    = 1'b0;
        retire_s  = 1'b0;
        resp_s    = '0;
        case (state_r)
            ST_IDLE: begin
                // settle_r masks the cycle where the previous owner still sees its ack
                if (!settle_r && (dreq_i.cyc || ireq_i.cyc)) begin
                    grant_s   = 1'b1;
                    grant_d_s = dreq_i.cyc && !(last_d_r && ireq_i.cyc);
                    win_req_s = grant_d_s ? dreq_i : ireq_i;
                    state_s   = ST_ISSUE;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (match_s && ftam_resp.ack) begin
                    resp_s.tid = ftam_resp.tid;
                    resp_s.ack = 1'b1;
                    resp_s.dat = ftam_resp.dat;
                    done_s     = 1'b1;
                    state_s    = ST_IDLE;
                end else if (match_s && ftam_resp.err) begin
                    resp_s.tid = ftam_resp.tid;
                    resp_s.err = 1'b1;
                    resp_s.dat = ftam_resp.dat;
                    done_s     = 1'b1;
                    state_s    = ST_IDLE;
                end else if (match_s && ftam_resp.rty) begin
                    state_s    = ST_BACKOFF;
                end else if (timeout_s) begin
                    resp_s.tid = '{core: CORENO, channel: CID, tranid: cur_tid_r};
                    resp_s.err = 1'b1;
                    done_s     = 1'b1;
                    retire_s   = 1'b1;
                    state_s    = ST_IDLE;
                end else begin
                    state_s    = ST_WAIT;
                end
            end
            ST_BACKOFF: begin
                if (bo_cnt_r == 8'(RTY_BACKOFF)) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_BACKOFF;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Bus request for the coming cycle; a fresh grant is issued straight from the winner.
    always_comb begin
        ftam_req_s  = '0;
        issue_src_s = (state_r == ST_IDLE) ? win_req_s : hold_r;
        if (state_s == ST_ISSUE) begin
            ftam_req_s             = issue_src_s;
            ftam_req_s.cyc         = 1'b1;
            ftam_req_s.stb         = 1'b1;
            ftam_req_s.tid.core    = CORENO;
            ftam_req_s.tid.channel = CID;
            ftam_req_s.tid.tranid  = (state_r == ST_IDLE) ? next_tid_r : cur_tid_r;
        end else begin
            ftam_req_s             = '0;
        end
    end

    // State, transaction bookkeeping and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r    <= ST_IDLE;
            hold_r     <= '0;
            owner_d_r  <= 1'b0;
            last_d_r   <= 1'b0;
            settle_r   <= 1'b0;
            cur_tid_r  <= 4'd0;
            next_tid_r <= 4'd1;
            bo_cnt_r   <= 8'd0;
            ftam_req_r <= '0;
            iresp_r    <= '0;
            dresp_r    <= '0;
        end else begin
            state_r    <= state_s;
            ftam_req_r <= ftam_req_s;
            settle_r   <= done_s;
            bo_cnt_r   <= (state_r == ST_BACKOFF) ? bo_cnt_r + 8'd1 : 8'd0;
            iresp_r    <= '0;
            dresp_r    <= '0;
            if (grant_s) begin
                hold_r     <= win_req_s;
                owner_d_r  <= grant_d_s;
                last_d_r   <= grant_d_s;
                cur_tid_r  <= next_tid_r;
                next_tid_r <= (next_tid_r == 4'd15) ? 4'd1 : next_tid_r + 4'd1;
            end else if (retire_s) begin
                cur_tid_r  <= 4'd0;
            end
            if (done_s && owner_cyc_s) begin
                if (owner_d_r) begin
                    dresp_r <= resp_s;
                end else begin
                    iresp_r <= resp_s;
                end
            end
        end
    end

`ifdef RF80386_ARB_TIMEOUT_EN
    // Cycles since the current (re)issue.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            to_cnt_r <= 10'd0;
        end else if (state_s == ST_ISSUE) begin
            to_cnt_r <= 10'd0;
        end else if (state_r == ST_ISSUE || state_r == ST_WAIT) begin
            to_cnt_r <= to_cnt_r + 10'd1;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end
`endif

    assign ftam_req = ftam_req_r;
    assign iresp_o  = iresp_r;
    assign dresp_o  = dresp_r;
    assign busy_o   = (state_r != ST_IDLE);

endmodule

// File: tb/tb_rf80386_bus_arb.sv
// Directed bench for rf80386_bus_arb: arbitration order, TID stamping, retry backoff, stale drops, reset.
module tb_rf80386_bus_arb;
    import rf80386_fta_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_i;
    fta_cmd_request128_t  ireq_i, dreq_i, ftam_req;
    fta_cmd_response128_t iresp_o, dresp_o, ftam_resp;
    logic                 busy_o;
    int                   tests_run = 0;
    int                   tests_failed = 0;
    int                   n;

    always #5 clk = ~clk;

    rf80386_bus_arb #(
        .CORENO(6'd1), .CID(3'd1), .RTY_BACKOFF(8), .TIMEOUT(64)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ireq_i(ireq_i), .iresp_o(iresp_o),
        .dreq_i(dreq_i), .dresp_o(dresp_o),
        .ftam_req(ftam_req), .ftam_resp(ftam_resp),
        .busy_o(busy_o)
    );

    task automatic check_eq(input string tag, input logic [191:0] act, input logic [191:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic fta_cmd_request128_t mk_req(input logic [31:0] adr);
        fta_cmd_request128_t r;
        r     = '0;
        r.cmd = CMD_LOAD;
        r.cyc = 1'b1;
        r.stb = 1'b1;
        r.sel = 16'hFFFF;
        r.adr = adr;
        return r;
    endfunction

    // Ticks until ftam_req.cyc is seen, bounded; returns cycles taken.
    task automatic wait_issue(input string tag, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!ftam_req.cyc && cycles < 60);
        check_eq({tag, "_issued"}, 192'(ftam_req.cyc), 192'd1);
    endtask

    // Drives one bus response cycle; returns in the cycle after it.
    task automatic respond(input logic [3:0] tid, input logic ack, input logic err,
                           input logic rty, input logic [127:0] dat);
        ftam_resp                = '0;
        ftam_resp.tid.core       = 6'd1;
        ftam_resp.tid.channel    = 3'd1;
        ftam_resp.tid.tranid     = tid;
        ftam_resp.ack            = ack;
        ftam_resp.err            = err;
        ftam_resp.rty            = rty;
        ftam_resp.dat            = dat;
        tick();
        ftam_resp = '0;
    endtask

    task automatic do_reset();
        ireq_i = '0;
        dreq_i = '0;
        rst_i  = 1'b0;
        tick();
        tick();
        rst_i  = 1'b1;
    endtask

    initial begin
        ireq_i    = '0;
        dreq_i    = '0;
        ftam_resp = '0;
        rst_i     = 1'b0;
        tick();
        tick();
        check_eq("rst_busy", 192'(busy_o), 192'd0);
        check_eq("rst_ftam_req", 192'(ftam_req), 192'd0);
        check_eq("rst_iresp", 192'(iresp_o), 192'd0);
        check_eq("rst_dresp", 192'(dresp_o), 192'd0);
        rst_i = 1'b1;

        // Single data read: issue at N+1, ack at N+4, forwarded at N+5.
        dreq_i = mk_req(32'h100);
        wait_issue("rd", n);
        check_eq("rd_latency", 192'(n), 192'd1);
        check_eq("rd_tranid", 192'(ftam_req.tid.tranid), 192'd1);
        check_eq("rd_core_chan", 192'({ftam_req.tid.core, ftam_req.tid.channel}), 192'({6'd1, 3'd1}));
        check_eq("rd_adr", 192'(ftam_req.adr), 192'h100);
        check_eq("rd_busy", 192'(busy_o), 192'd1);
        tick();
        check_eq("rd_one_pulse", 192'(ftam_req.cyc), 192'd0);
        tick();
        tick();
        respond(4'd1, 1'b1, 1'b0, 1'b0, 128'h1234);
        check_eq("rd_dack", 192'(dresp_o.ack), 192'd1);
        check_eq("rd_ddat", 192'(dresp_o.dat), 192'h1234);
        check_eq("rd_iresp_quiet", 192'(iresp_o), 192'd0);
        check_eq("rd_idle", 192'(busy_o), 192'd0);
        dreq_i = '0;
        tick();
        check_eq("rd_ack_once", 192'(dresp_o.ack), 192'd0);

        // Owner abandons: transaction completes but nothing is forwarded.
        dreq_i = mk_req(32'h200);
        wait_issue("drop", n);
        check_eq("drop_tranid", 192'(ftam_req.tid.tranid), 192'd2);
        dreq_i = '0;
        tick();
        respond(4'd2, 1'b1, 1'b0, 1'b0, 128'hABCD);
        check_eq("drop_no_fwd", 192'(dresp_o), 192'd0);
        check_eq("drop_idle", 192'(busy_o), 192'd0);

        // Both requesters held continuously from reset: D, I, D, I.
        do_reset();
        dreq_i = mk_req(32'h300);
        ireq_i = mk_req(32'h400);
        for (int i = 0; i < 4; i++) begin
            logic exp_d;
            exp_d = (i % 2 == 0);
            wait_issue("rr", n);
            check_eq("rr_tranid", 192'(ftam_req.tid.tranid), 192'(i + 1));
            check_eq("rr_owner_adr", 192'(ftam_req.adr), exp_d ? 192'h300 : 192'h400);
            tick();
            respond(4'(i + 1), 1'b1, 1'b0, 1'b0, 128'(i + 16));
            check_eq("rr_dack", 192'(dresp_o.ack), 192'(exp_d));
            check_eq("rr_iack", 192'(iresp_o.ack), 192'(!exp_d));
        end
        dreq_i = '0;
        ireq_i = '0;
        tick();
        tick();

        // Retry: rty at M, reissue at M+10, then ack+rty together (ack wins).
        do_reset();
        dreq_i = mk_req(32'h500);
        wait_issue("rty", n);
        tick();
        respond(4'd1, 1'b0, 1'b0, 1'b1, 128'h0);
        check_eq("rty_no_fwd", 192'(dresp_o), 192'd0);
        check_eq("rty_busy", 192'(busy_o), 192'd1);
        n = 1;
        while (!ftam_req.cyc && n < 40) begin
            tick();
            n++;
        end
        check_eq("rty_reissue_cycle", 192'(n), 192'd10);
        check_eq("rty_same_tranid", 192'(ftam_req.tid.tranid), 192'd1);
        tick();
        respond(4'd1, 1'b1, 1'b0, 1'b1, 128'h55);
        check_eq("rty_ack_wins", 192'(dresp_o.ack), 192'd1);
        check_eq("rty_ack_dat", 192'(dresp_o.dat), 192'h55);
        check_eq("rty_done_idle", 192'(busy_o), 192'd0);
        dreq_i = '0;
        tick();
        check_eq("rty_ack_once", 192'(dresp_o.ack), 192'd0);

        // 16 back-to-back grants; stale tid 3 during WAIT for tid 5 dropped.
        do_reset();
        dreq_i = mk_req(32'h600);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] exp_tid;
            exp_tid = 4'((i % 15) + 1);
            wait_issue("b2b", n);
            check_eq("b2b_tranid", 192'(ftam_req.tid.tranid), 192'(exp_tid));
            tick();
            if (i == 4) begin
                respond(4'd3, 1'b1, 1'b0, 1'b0, 128'hDEAD);
                check_eq("stale_dropped", 192'(dresp_o.ack), 192'd0);
                check_eq("stale_still_busy", 192'(busy_o), 192'd1);
            end
            respond(exp_tid, 1'b1, 1'b0, 1'b0, 128'(i));
            check_eq("b2b_ack", 192'(dresp_o.ack), 192'd1);
        end

        // Reset during WAIT abandons the transaction; TID restarts at 1.
        wait_issue("rstw", n);
        check_eq("rstw_tranid", 192'(ftam_req.tid.tranid), 192'd2);
        tick();
        rst_i  = 1'b0;
        dreq_i = '0;
        tick();
        rst_i  = 1'b1;
        check_eq("rstw_busy", 192'(busy_o), 192'd0);
        check_eq("rstw_ftam_req", 192'(ftam_req), 192'd0);
        check_eq("rstw_dresp", 192'(dresp_o), 192'd0);
        check_eq("rstw_iresp", 192'(iresp_o), 192'd0);
        tick();
        respond(4'd2, 1'b1, 1'b0, 1'b0, 128'h77);
        check_eq("rstw_late_dropped", 192'(dresp_o), 192'd0);
        ireq_i = mk_req(32'h700);
        wait_issue("rstw_next", n);
        check_eq("rstw_next_tranid", 192'(ftam_req.tid.tranid), 192'd1);
        tick();
        respond(4'd1, 1'b1, 1'b0, 1'b0, 128'h88);
        check_eq("rstw_next_iack", 192'(iresp_o.ack), 192'd1);
        ireq_i = '0;
        tick();

`ifdef RF80386_ARB_TIMEOUT_EN
        // Lost transaction: err exactly 64 cycles after ISSUE; late ack dropped.
        ireq_i = mk_req(32'h800);
        wait_issue("to", n);
        check_eq("to_tranid", 192'(ftam_req.tid.tranid), 192'd2);
        n = 0;
        while (!iresp_o.err && n < 100) begin
            tick();
            n++;
        end
        check_eq("to_err_cycle", 192'(n), 192'd64);
        check_eq("to_no_ack", 192'(iresp_o.ack), 192'd0);
        check_eq("to_idle", 192'(busy_o), 192'd0);
        ireq_i = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        respond(4'd2, 1'b1, 1'b0, 1'b0, 128'h99);
        check_eq("to_late_dropped", 192'(iresp_o), 192'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
